logic_unit_lockstep: RTL and testbench

//  Parametrised, registered bitwise logic unit with operation select and a

---
 rtl/logic_unit_lockstep.sv | 157 +++++++++++++++
 tb/tb_logic_unit_lockstep.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_lockstep.sv
// Registered bitwise logic unit with a lockstep self-check: path A from gate
// primitives drives the result, path B (expression) cross-checks it.
module logic_unit_lockstep #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             fault_inj,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             mismatch,
  input  logic             clr_err,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic               accept_s;
  logic [WIDTH-1:0]   nor_s, nand_s, and_s, or_s, xor_s, xnor_s, not_s, buf_s;
  logic [WIDTH-1:0]   path_a_s;
  logic [WIDTH-1:0]   path_b_s;
  logic [WIDTH-1:0]   path_b_f_s;
  logic               mismatch_s;
  logic [WIDTH-1:0]   s_r;
  logic               mismatch_r;
  logic               err_sticky_r;
  logic [CNT_W-1:0]   err_count_r;

  // Path A: one primitive of each kind per bit, selected afterwards.
  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_bit
      nor  u_nor  (nor_s[i],  a[i], b[i]);
      nand u_nand (nand_s[i], a[i], b[i]);
      and  u_and  (and_s[i],  a[i], b[i]);
      or   u_or   (or_s[i],   a[i], b[i]);
      xor  u_xor  (xor_s[i],  a[i], b[i]);
      xnor u_xnor (xnor_s[i], a[i], b[i]);
      not  u_not  (not_s[i],  a[i]);
      buf  u_buf  (buf_s[i],  a[i]);
    end
  endgenerate

  // Path A operation select.
  always_comb begin
    path_a_s = {WIDTH{1'b0}};
    case (op)
      3'b000:  path_a_s = nor_s;
      3'b001:  path_a_s = nand_s;
      3'b010:  path_a_s = and_s;
      3'b011:  path_a_s = or_s;
      3'b100:  path_a_s = xor_s;
      3'b101:  path_a_s = xnor_s;
      3'b110:  path_a_s = not_s;
      3'b111:  path_a_s = buf_s;
      default: path_a_s = {WIDTH{1'b0}};
    endcase
  end

  // Path B is deliberately written as an independent expression.
  assign path_b_s = (op == 3'b000) ? ~(a | b) :
                    (op == 3'b001) ? ~(a & b) :
                    (op == 3'b010) ?  (a & b) :
                    (op == 3'b011) ?  (a | b) :
                    (op == 3'b100) ?  (a ^ b) :
                    (op == 3'b101) ? ~(a ^ b) :
                    (op == 3'b110) ? ~a       : a;

  assign path_b_f_s = path_b_s ^ WIDTH'(fault_inj);
  assign mismatch_s = |(path_a_s ^ path_b_f_s);
  assign accept_s   = in_valid && in_ready;

  // Output stage state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output stage next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      EMPTY:   state_nxt_s = accept_s ? FULL : EMPTY;
      FULL:    state_nxt_s = (out_ready && !accept_s) ? EMPTY : FULL;
      default: state_nxt_s = EMPTY;
    endcase
  end

  // Output stage handshake outputs.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 1'b1;
    if (state_r == FULL) begin
      out_valid = 1'b1;
      in_ready  = out_ready;
    end else begin
      out_valid = 1'b0;
      in_ready  = 1'b1;
    end
  end

  // Result register: only loads on an accepted beat, otherwise holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_r        <= {WIDTH{1'b0}};
      mismatch_r <= 1'b0;
    end else if (accept_s) begin
      s_r        <= path_a_s;
      mismatch_r <= mismatch_s;
    end else begin
      s_r        <= s_r;
      mismatch_r <= mismatch_r;
    end
  end

  // Error tracking; a mismatching beat wins over a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sticky_r <= 1'b0;
      err_count_r  <= {CNT_W{1'b0}};
    end else if (accept_s && mismatch_s) begin
      err_sticky_r <= 1'b1;
      if (clr_err) begin
        err_count_r <= CNT_W'(1);
      end else if (err_count_r != {CNT_W{1'b1}}) begin
        err_count_r <= err_count_r + CNT_W'(1);
      end else begin
        err_count_r <= err_count_r;
      end
    end else if (clr_err) begin
      err_sticky_r <= 1'b0;
      err_count_r  <= {CNT_W{1'b0}};
    end else begin
      err_sticky_r <= err_sticky_r;
      err_count_r  <= err_count_r;
    end
  end

  assign s          = s_r;
  assign mismatch   = mismatch_r;
  assign err_sticky = err_sticky_r;
  assign err_count  = err_count_r;

endmodule

// File: tb/tb_logic_unit_lockstep.sv
// Self-checking bench for logic_unit_lockstep: table-driven vectors into a
// scoreboard queue plus hand-written backpressure, fault and reset sequences.
module tb_logic_unit_lockstep;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] a, b;
  logic [2:0] op;
  logic       fault_inj;
  logic       out_ready;
  logic       clr_err;

  logic       in_ready, out_valid, mismatch, err_sticky;
  logic [7:0] s, err_count;
  logic       in_ready2, out_valid2, mismatch2, err_sticky2;
  logic [7:0] s2;
  logic [1:0] err_count2;

  logic [7:0] exp_s_d;
  logic       exp_mm_d;

  int checks = 0;
  int errors = 0;

  logic [8:0] q[$];
  logic       tb_full;
  logic       acc;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_s;
  } vec_t;

  vec_t vecs[13];

  logic_unit_lockstep #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .op(op), .fault_inj(fault_inj),
    .out_valid(out_valid), .out_ready(out_ready), .s(s), .mismatch(mismatch),
    .clr_err(clr_err), .err_sticky(err_sticky), .err_count(err_count)
  );

  logic_unit_lockstep #(.WIDTH(8), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .op(op), .fault_inj(fault_inj),
    .out_valid(out_valid2), .out_ready(out_ready), .s(s2), .mismatch(mismatch2),
    .clr_err(clr_err), .err_sticky(err_sticky2), .err_count(err_count2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] o, input logic [7:0] va, input logic [7:0] vb,
                       input logic f, input logic [7:0] es, input logic emm);
    in_valid  = 1'b1;
    op        = o;
    a         = va;
    b         = vb;
    fault_inj = f;
    exp_s_d   = es;
    exp_mm_d  = emm;
  endtask

  task automatic idle();
    in_valid  = 1'b0;
    fault_inj = 1'b0;
    op        = 3'bxxx;
    a         = 8'hxx;
    b         = 8'hxx;
  endtask

  // Scoreboard: predicts handshake, pushes expected on accept, compares held result.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      tb_full = 1'b0;
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, tb_full});
      chk("in_ready", {31'd0, in_ready}, {31'd0, (!tb_full || out_ready)});
      if (tb_full) begin
        if (q.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          chk("s", {24'd0, s}, {24'd0, q[0][8:1]});
          chk("s_cnt2", {24'd0, s2}, {24'd0, q[0][8:1]});
          chk("mismatch", {31'd0, mismatch}, {31'd0, q[0][0]});
          if (out_ready) void'(q.pop_front());
        end
      end
      acc = in_valid && (!tb_full || out_ready);
      if (acc) q.push_back({exp_s_d, exp_mm_d});
      tb_full = acc ? 1'b1 : (out_ready ? 1'b0 : tb_full);
    end
  end

  initial begin
    vecs[0]  = '{3'b000, 8'hF0, 8'hCC, 8'h03};
    vecs[1]  = '{3'b001, 8'hF0, 8'hCC, 8'h3F};
    vecs[2]  = '{3'b010, 8'hF0, 8'hCC, 8'hC0};
    vecs[3]  = '{3'b011, 8'hF0, 8'hCC, 8'hFC};
    vecs[4]  = '{3'b100, 8'hF0, 8'hCC, 8'h3C};
    vecs[5]  = '{3'b101, 8'hF0, 8'hCC, 8'hC3};
    vecs[6]  = '{3'b110, 8'hF0, 8'hCC, 8'h0F};
    vecs[7]  = '{3'b111, 8'hF0, 8'hCC, 8'hF0};
    vecs[8]  = '{3'b010, 8'hAA, 8'h55, 8'h00};
    vecs[9]  = '{3'b100, 8'hAA, 8'h55, 8'hFF};
    vecs[10] = '{3'b001, 8'hFF, 8'hFF, 8'h00};
    vecs[11] = '{3'b110, 8'h5A, 8'h00, 8'hA5};
    vecs[12] = '{3'b111, 8'h5A, 8'hFF, 8'h5A};

    rst_n = 1'b0; out_ready = 1'b1; clr_err = 1'b0;
    exp_s_d = 8'h00; exp_mm_d = 1'b0; tb_full = 1'b0;
    idle();
    tick(); tick();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_s", {24'd0, s}, 32'd0);
    chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
    chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    chk("rst_err_count", {24'd0, err_count}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst_n = 1'b1;
    tick();

    // Truth table and extra patterns, full throughput.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].exp_s, 1'b0);
      tick();
    end
    idle();
    tick(); tick();

    // Backpressure: held result, new inputs ignored.
    out_ready = 1'b0;
    drive(3'b000, 8'h00, 8'h00, 1'b0, 8'hFF, 1'b0);
    tick();
    drive(3'b010, 8'hF0, 8'hCC, 1'b1, 8'hC0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_s_held", {24'd0, s}, 32'h0000_00FF);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    idle();
    out_ready = 1'b1;
    tick();
    chk("bp_taken", {31'd0, out_valid}, 32'd0);

    // Back-to-back beats.
    for (int i = 0; i < 4; i++) begin
      drive(3'b100, 8'(i * 17), 8'hFF, 1'b0, 8'(i * 17) ^ 8'hFF, 1'b0);
      tick();
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      chk("b2b_out_valid", {31'd0, out_valid}, 32'd1);
    end
    idle();
    tick();

    // Fault injection on 3 beats, then clear.
    for (int i = 0; i < 3; i++) begin
      drive(3'b011, 8'h0F, 8'hF0, 1'b1, 8'hFF, 1'b1);
      tick();
    end
    idle();
    tick();
    chk("flt_sticky", {31'd0, err_sticky}, 32'd1);
    chk("flt_count", {24'd0, err_count}, 32'd3);
    chk("flt_count2", {30'd0, err_count2}, 32'd3);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_sticky", {31'd0, err_sticky}, 32'd0);
    chk("clr_count", {24'd0, err_count}, 32'd0);
    chk("clr_count2", {30'd0, err_count2}, 32'd0);

    // Saturation at CNT_W=2, then clear racing a faulted beat.
    for (int i = 0; i < 5; i++) begin
      drive(3'b101, 8'h33, 8'h0F, 1'b1, 8'hC3, 1'b1);
      tick();
    end
    idle();
    tick();
    chk("sat_count2", {30'd0, err_count2}, 32'd3);
    chk("sat_count8", {24'd0, err_count}, 32'd5);
    clr_err = 1'b1;
    drive(3'b000, 8'h01, 8'h02, 1'b1, 8'hFC, 1'b1);
    tick();
    clr_err = 1'b0;
    idle();
    chk("race_count2", {30'd0, err_count2}, 32'd1);
    chk("race_sticky2", {31'd0, err_sticky2}, 32'd1);
    chk("race_count8", {24'd0, err_count}, 32'd1);
    tick();
    // A clean beat must not move the counters.
    drive(3'b010, 8'hFF, 8'h81, 1'b0, 8'h81, 1'b0);
    tick();
    idle();
    tick();
    chk("clean_count8", {24'd0, err_count}, 32'd1);

    // Mid-stream asynchronous reset with a held result.
    out_ready = 1'b0;
    drive(3'b111, 8'h77, 8'h00, 1'b0, 8'h77, 1'b0);
    tick();
    idle();
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_s", {24'd0, s}, 32'd0);
    chk("async_mismatch", {31'd0, mismatch}, 32'd0);
    chk("async_sticky", {31'd0, err_sticky}, 32'd0);
    chk("async_count", {24'd0, err_count}, 32'd0);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("post_rst_valid", {31'd0, out_valid}, 32'd0);
    tick();
    chk("sb_drained", q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
